// File: rtl/mac_pkg.sv
// Shared Ethernet MAC definitions used by the tx header inserter and the
// rx header stripper.
package mac_pkg;

  localparam int ETH_HDR_LEN   = 14;
  localparam int ETH_MIN_FRAME = 60;
  localparam int ETH_MAX_FRAME = 1514;

  typedef logic [47:0] mac_addr_t;
  typedef logic [15:0] eth_type_t;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PLD,
    PAD,
    DROP
  } tx_hdr_state_t;

endpackage

// File: rtl/mac_tx_header_insert.sv
// Builds an Ethernet frame (no FCS) for the MAC transmit path: 14-byte
// header from a descriptor, payload passed straight through, zero padding
// up to the minimum length, and truncation of over-length payloads.
module mac_tx_header_insert
  import mac_pkg::*;
#(
  parameter mac_addr_t LOCAL_MAC = 48'h00_0A_35_00_00_01,
  parameter int        MIN_FRAME = ETH_MIN_FRAME,
  parameter int        MAX_FRAME = ETH_MAX_FRAME
) (
  input  logic        logic_clk,
  input  logic        logic_rst,
  input  logic [47:0] hdr_dst_mac_in,
  input  logic [15:0] hdr_type_in,
  input  logic        hdr_valid_in,
  output logic        hdr_ready_out,
  input  logic [7:0]  pld_tdata_in,
  input  logic        pld_tvalid_in,
  output logic        pld_tready_out,
  input  logic        pld_tlast_in,
  output logic [7:0]  mac_tdata_out,
  output logic        mac_tvalid_out,
  input  logic        mac_tready_in,
  output logic        mac_tlast_out,
  output logic        trunc_pulse_out
);

  localparam logic [10:0] HDR_LAST = 11'(ETH_HDR_LEN - 1);
  localparam logic [10:0] MIN_LAST = 11'(MIN_FRAME - 1);
  localparam logic [10:0] MAX_LAST = 11'(MAX_FRAME - 1);

  tx_hdr_state_t state;
  logic [10:0]   byte_cnt;
  mac_addr_t     dst_q;
  eth_type_t     type_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          last_q;
  logic          trunc_q;

  // 14-way header byte select: dst, source (LOCAL_MAC), EtherType, MSB first.
  function automatic logic [7:0] hdr_byte(input mac_addr_t dst, input eth_type_t typ,
                                          input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:    b = dst[47:40];
      4'd1:    b = dst[39:32];
      4'd2:    b = dst[31:24];
      4'd3:    b = dst[23:16];
      4'd4:    b = dst[15:8];
      4'd5:    b = dst[7:0];
      4'd6:    b = LOCAL_MAC[47:40];
      4'd7:    b = LOCAL_MAC[39:32];
      4'd8:    b = LOCAL_MAC[31:24];
      4'd9:    b = LOCAL_MAC[23:16];
      4'd10:   b = LOCAL_MAC[15:8];
      4'd11:   b = LOCAL_MAC[7:0];
      4'd12:   b = typ[15:8];
      4'd13:   b = typ[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Output steering: registered header/pad bytes, or live payload in PLD.
  // Reset forces every output quiet even before the reset edge lands.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    hdr_ready_out  = 1'b0;
    pld_tready_out = 1'b0;
    mac_tdata_out  = data_q;
    mac_tvalid_out = valid_q;
    mac_tlast_out  = last_q;
    if (logic_rst) begin
      mac_tdata_out  = 8'h00;
      mac_tvalid_out = 1'b0;
      mac_tlast_out  = 1'b0;
    end else begin
      case (state)
        IDLE: hdr_ready_out = 1'b1;
        PLD: begin
          mac_tdata_out  = pld_tdata_in;
          mac_tvalid_out = pld_tvalid_in;
          pld_tready_out = mac_tready_in;
          mac_tlast_out  = pld_tvalid_in &&
                           (pld_tlast_in ? (byte_cnt >= MIN_LAST) : (byte_cnt == MAX_LAST));
        end
        DROP: pld_tready_out = 1'b1;
        default: ;
      endcase
    end
  end

  assign trunc_pulse_out = trunc_q && !logic_rst;

  // Frame sequencer: descriptor latch, header walk, payload count, pad, drop.
  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      // NOTE: only control and the small header latch are reset; no storage array exists here.
      state    <= IDLE;
      byte_cnt <= 11'd0;
      dst_q    <= '0;
      type_q   <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      trunc_q <= 1'b0;
      case (state)
        IDLE: begin
          if (hdr_valid_in) begin
            dst_q    <= hdr_dst_mac_in;
            type_q   <= hdr_type_in;
            byte_cnt <= 11'd0;
            data_q   <= hdr_byte(hdr_dst_mac_in, hdr_type_in, 4'd0);
            valid_q  <= 1'b1;
            last_q   <= 1'b0;
            state    <= HDR;
          end
        end
        HDR: begin
          if (mac_tready_in) begin
            byte_cnt <= byte_cnt + 11'd1;
            if (byte_cnt == HDR_LAST) begin
              valid_q <= 1'b0;
              data_q  <= 8'h00;
              state   <= PLD;
            end else begin
              data_q <= hdr_byte(dst_q, type_q, byte_cnt[3:0] + 4'd1);
            end
          end
        end
        PLD: begin
          if (pld_tvalid_in && mac_tready_in) begin
            byte_cnt <= byte_cnt + 11'd1;
            if (pld_tlast_in) begin
              if (byte_cnt >= MIN_LAST) begin
                state <= IDLE;
              end else begin
                data_q  <= 8'h00;
                valid_q <= 1'b1;
                last_q  <= (byte_cnt + 11'd1 == MIN_LAST);
                state   <= PAD;
              end
            end else if (byte_cnt == MAX_LAST) begin
              trunc_q <= 1'b1;
              state   <= DROP;
            end
          end
        end
        PAD: begin
          if (mac_tready_in) begin
            byte_cnt <= byte_cnt + 11'd1;
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state   <= IDLE;
            end else begin
              last_q <= (byte_cnt + 11'd1 == MIN_LAST);
            end
          end
        end
        DROP: begin
          if (pld_tvalid_in && pld_tlast_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_header_insert.sv
// Directed-sequence bench for mac_tx_header_insert with randomized payloads
// and handshakes, checked against a frame-level reference model.
module tb_mac_tx_header_insert;

  localparam logic [47:0] LOCAL_MAC = 48'h00_0A_35_00_00_01;

  logic        logic_clk = 1'b0;
  logic        logic_rst;
  logic [47:0] hdr_dst_mac_in;
  logic [15:0] hdr_type_in;
  logic        hdr_valid_in;
  logic        hdr_ready_out;
  logic [7:0]  pld_tdata_in;
  logic        pld_tvalid_in;
  logic        pld_tready_out;
  logic        pld_tlast_in;
  logic [7:0]  mac_tdata_out;
  logic        mac_tvalid_out;
  logic        mac_tready_in;
  logic        mac_tlast_out;
  logic        trunc_pulse_out;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [7:0] pld_q[$];
  logic [7:0] exp_q[$];

  mac_tx_header_insert dut (
    .logic_clk      (logic_clk),
    .logic_rst      (logic_rst),
    .hdr_dst_mac_in (hdr_dst_mac_in),
    .hdr_type_in    (hdr_type_in),
    .hdr_valid_in   (hdr_valid_in),
    .hdr_ready_out  (hdr_ready_out),
    .pld_tdata_in   (pld_tdata_in),
    .pld_tvalid_in  (pld_tvalid_in),
    .pld_tready_out (pld_tready_out),
    .pld_tlast_in   (pld_tlast_in),
    .mac_tdata_out  (mac_tdata_out),
    .mac_tvalid_out (mac_tvalid_out),
    .mac_tready_in  (mac_tready_in),
    .mac_tlast_out  (mac_tlast_out),
    .trunc_pulse_out(trunc_pulse_out)
  );

  always #5 logic_clk = ~logic_clk;

  always @(posedge logic_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idle_inputs();
    hdr_valid_in  = 1'b0;
    pld_tvalid_in = 1'b0;
    pld_tlast_in  = 1'b0;
    pld_tdata_in  = 8'h00;
    mac_tready_in = 1'b1;
  endtask

  task automatic fill_pld(input int len, input bit incrementing);
    pld_q = {};
    for (int i = 0; i < len; i++) pld_q.push_back(incrementing ? 8'(i + 1) : 8'($urandom));
  endtask

  // Reference frame: header, first 1500 payload bytes, zero pad to 60.
  task automatic build_exp(input logic [47:0] dst, input logic [15:0] typ);
    int n;
    exp_q = {};
    for (int i = 0; i < 6; i++) exp_q.push_back(dst[47 - 8*i -: 8]);
    for (int i = 0; i < 6; i++) exp_q.push_back(LOCAL_MAC[47 - 8*i -: 8]);
    exp_q.push_back(typ[15:8]);
    exp_q.push_back(typ[7:0]);
    n = (pld_q.size() > 1500) ? 1500 : pld_q.size();
    for (int i = 0; i < n; i++) exp_q.push_back(pld_q[i]);
    while (exp_q.size() < 60) exp_q.push_back(8'h00);
  endtask

  // Drives one descriptor plus pld_q and scores every output beat.
  // rst_at >= 0 aborts with a reset once that output beat is presented.
  task automatic run_frame(input logic [47:0] dst, input logic [15:0] typ, input bit rnd,
                           input int rst_at, input bit b2b);
    int         out_idx    = 0;
    int         pld_idx    = 0;
    int         trunc_cnt  = 0;
    int         hs_cyc     = -1;
    int         budget     = 0;
    int         len;
    bit         hdr_done   = 0;
    bit         seen_valid = 0;
    bit         hold_v     = 0;
    bit         prev_stall = 0;
    bit         first      = 1;
    bit         aborted    = 0;
    logic [7:0] prev_data  = 8'h00;
    len = pld_q.size();
    build_exp(dst, typ);
    forever begin
      @(posedge logic_clk);
      #1;
      hdr_dst_mac_in = dst;
      hdr_type_in    = typ;
      hdr_valid_in   = !hdr_done;
      if (pld_idx < len) begin
        if (!hold_v) pld_tvalid_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        pld_tdata_in = pld_q[pld_idx];
        pld_tlast_in = (pld_idx == len - 1);
      end else begin
        pld_tvalid_in = 1'b0;
        pld_tlast_in  = 1'b0;
        pld_tdata_in  = 8'h00;
      end
      mac_tready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge logic_clk);
      if (first && b2b) check("b2b_hdr_ready", hdr_ready_out, 1);
      first = 0;
      if (prev_stall) begin
        check("stall_valid", mac_tvalid_out, 1);
        check("stall_data", mac_tdata_out, prev_data);
      end
      if (out_idx < 14) check("pld_ready_hdr", pld_tready_out, 0);
      if (len < 46 && out_idx >= 14 + len && out_idx < 60) check("pld_ready_pad", pld_tready_out, 0);
      if (out_idx >= exp_q.size()) check("valid_after_last", mac_tvalid_out, 0);
      if (!seen_valid && mac_tvalid_out) begin
        seen_valid = 1;
        check("first_beat_latency", cyc - hs_cyc, 1);
      end
      if (mac_tvalid_out && mac_tready_in && out_idx < exp_q.size()) begin
        check($sformatf("data[%0d]", out_idx), mac_tdata_out, exp_q[out_idx]);
        check($sformatf("last[%0d]", out_idx), mac_tlast_out, out_idx == exp_q.size() - 1);
        out_idx++;
      end
      if (hdr_valid_in && hdr_ready_out) begin
        hdr_done = 1;
        hs_cyc   = cyc;
      end
      if (pld_tvalid_in && pld_tready_out) pld_idx++;
      if (trunc_pulse_out) trunc_cnt++;
      hold_v     = pld_tvalid_in && !pld_tready_out;
      prev_stall = mac_tvalid_out && !mac_tready_in;
      prev_data  = mac_tdata_out;
      budget++;
      if (rst_at >= 0 && out_idx == rst_at) begin
        aborted = 1;
        break;
      end
      if (out_idx == exp_q.size() && pld_idx == len) break;
      if (budget > 5000) begin
        check("frame_timeout", 1, 0);
        break;
      end
    end
    if (aborted) begin
      @(posedge logic_clk);
      #1;
      logic_rst = 1'b1;
      idle_inputs();
      @(posedge logic_clk);
      @(negedge logic_clk);
      check("abort_valid", mac_tvalid_out, 0);
      check("abort_pld_ready", pld_tready_out, 0);
      check("abort_last", mac_tlast_out, 0);
      check("abort_hdr_ready", hdr_ready_out, 0);
      @(posedge logic_clk);
      #1;
      logic_rst = 1'b0;
      @(negedge logic_clk);
      check("post_abort_valid", mac_tvalid_out, 0);
      check("post_abort_hdr_ready", hdr_ready_out, 1);
    end else begin
      check("trunc_pulses", trunc_cnt, (len > 1500) ? 1 : 0);
    end
  endtask

  initial begin
    logic_rst      = 1'b1;
    hdr_dst_mac_in = '0;
    hdr_type_in    = '0;
    idle_inputs();
    repeat (3) @(posedge logic_clk);
    @(negedge logic_clk);
    check("rst_hdr_ready", hdr_ready_out, 0);
    check("rst_valid", mac_tvalid_out, 0);
    check("rst_last", mac_tlast_out, 0);
    check("rst_data", mac_tdata_out, 0);
    check("rst_pld_ready", pld_tready_out, 0);
    check("rst_trunc", trunc_pulse_out, 0);
    @(posedge logic_clk);
    #1;
    logic_rst = 1'b0;
    @(negedge logic_clk);
    check("post_rst_valid", mac_tvalid_out, 0);
    check("post_rst_data", mac_tdata_out, 0);
    check("post_rst_pld_ready", pld_tready_out, 0);
    check("post_rst_hdr_ready", hdr_ready_out, 1);

    // Exactly minimum-length frame, no padding.
    fill_pld(46, 1);
    run_frame(48'hFFFF_FFFF_FFFF, 16'h0806, 0, -1, 0);

    // Short payload padded to 60.
    fill_pld(10, 0);
    run_frame(48'h0011_2233_4455, 16'h0800, 0, -1, 0);

    // One byte short of minimum: a single pad byte carries tlast.
    fill_pld(45, 0);
    run_frame(48'h0200_0000_0001, 16'h88B5, 0, -1, 0);

    // Exactly maximum length: tlast from payload, no truncation.
    fill_pld(1500, 0);
    run_frame(48'h0A0B_0C0D_0E0F, 16'h0800, 0, -1, 0);

    // Over-length payload: truncated at 1514, remaining 100 bytes dropped.
    fill_pld(1600, 0);
    run_frame(48'h1234_5678_9ABC, 16'h86DD, 0, -1, 0);
    @(posedge logic_clk);
    #1;
    idle_inputs();
    @(negedge logic_clk);
    check("trunc_back_to_idle", hdr_ready_out, 1);
    check("trunc_idle_valid", mac_tvalid_out, 0);

    // Same 100-byte payload with smooth and randomly stalled handshakes.
    fill_pld(100, 0);
    run_frame(48'h5254_0012_3456, 16'h0800, 0, -1, 0);
    run_frame(48'h5254_0012_3456, 16'h0800, 1, -1, 0);
    fill_pld(30, 0);
    run_frame(48'h0102_0304_0506, 16'h0806, 1, -1, 0);

    // Reset at header byte 7, then a clean frame.
    fill_pld(50, 0);
    run_frame(48'hDEAD_BEEF_0001, 16'h0800, 0, 7, 0);
    run_frame(48'hDEAD_BEEF_0002, 16'h0800, 0, -1, 0);

    // Reset at payload byte 20, then a clean frame.
    fill_pld(50, 0);
    run_frame(48'hCAFE_0000_0001, 16'h0800, 0, 34, 0);
    fill_pld(20, 0);
    run_frame(48'hCAFE_0000_0002, 16'h0806, 0, -1, 0);

    // Back-to-back frames.
    fill_pld(64, 0);
    run_frame(48'h0000_1111_2222, 16'h0800, 0, -1, 0);
    fill_pld(12, 0);
    run_frame(48'h0000_3333_4444, 16'h0806, 0, -1, 1);

    @(posedge logic_clk);
    #1;
    idle_inputs();
    repeat (2) @(posedge logic_clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
